// File: rtl/oh_fifo_wr_arbiter.sv
// Packet-atomic round-robin arbiter for the shared write port of the async FIFO.
// Words are tagged {owner id, last, data}; stalled packets are force-released after TIMEOUT.
module oh_fifo_wr_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned DW      = 32,
    parameter int unsigned IW      = $clog2(N),
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned TW      = $clog2(TIMEOUT + 1)
) (
    input  logic            wr_clk,
    input  logic            wr_nreset,
    input  logic [N-1:0]    req_valid,
    input  logic [N-1:0]    req_last,
    input  logic [N*DW-1:0] req_data,
    output logic [N-1:0]    req_ready,
    input  logic            fifo_full,
    input  logic            fifo_prog_full,
    output logic            fifo_wr_en,
    output logic [DW+IW:0]  fifo_din,
    output logic [N-1:0]    grant,
    output logic            busy,
    output logic            err_timeout,
    input  logic            err_clr
);

    typedef enum logic {StIdle, StLock} state_e;

    state_e        state_q;
    logic [N-1:0]  grant_q;
    logic [IW-1:0] grant_id_q;
    logic [IW-1:0] rr_ptr_q;
    logic [TW-1:0] stall_cnt_q;
    logic          err_timeout_q;

    logic [DW-1:0] data_arr [N];
    logic [IW-1:0] pick_id;
    logic [IW-1:0] cand;
    logic          pick_found;
    logic          lock;
    logic          owner_valid;
    logic          owner_last;
    logic          xfer;
    logic          stall;
    logic          timeout_hit;
    logic [IW-1:0] next_ptr;

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*DW +: DW];
    end

    // First valid requester at or after rr_ptr, wrapping modulo N.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (int'(rr_ptr_q) + k >= int'(N)) begin
                cand = IW'(int'(rr_ptr_q) + k - int'(N));
            end else begin
                cand = IW'(int'(rr_ptr_q) + k);
            end
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    always_comb begin
        lock        = (state_q == StLock);
        owner_valid = req_valid[grant_id_q];
        owner_last  = req_last[grant_id_q];
        xfer        = lock & owner_valid & ~fifo_full;
        // Backpressure with valid held is not a stall; only a missing valid counts.
        stall       = lock & ~owner_valid;
        timeout_hit = stall && (stall_cnt_q == TW'(TIMEOUT - 1));
        next_ptr    = (grant_id_q == IW'(N - 1)) ? '0 : grant_id_q + IW'(1);
    end

    always_comb begin
        req_ready  = (lock && !fifo_full) ? grant_q : '0;
        fifo_wr_en = xfer;
        fifo_din   = {grant_id_q, lock & owner_last, data_arr[grant_id_q]};
    end

    always_ff @(posedge wr_clk or negedge wr_nreset) begin
        if (!wr_nreset) begin
            state_q       <= StIdle;
            grant_q       <= '0;
            grant_id_q    <= '0;
            rr_ptr_q      <= '0;
            stall_cnt_q   <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            if (err_clr) begin
                err_timeout_q <= 1'b0;
            end
            case (state_q)
                StIdle: begin
                    if (pick_found && !fifo_prog_full) begin
                        state_q     <= StLock;
                        grant_id_q  <= pick_id;
                        grant_q     <= N'(1) << pick_id;
                        stall_cnt_q <= '0;
                    end
                end
                StLock: begin
                    if (xfer) begin
                        stall_cnt_q <= '0;
                        if (owner_last) begin
                            state_q  <= StIdle;
                            grant_q  <= '0;
                            rr_ptr_q <= next_ptr;
                        end
                    end else if (timeout_hit) begin
                        state_q       <= StIdle;
                        grant_q       <= '0;
                        rr_ptr_q      <= next_ptr;
                        stall_cnt_q   <= '0;
                        err_timeout_q <= 1'b1;
                    end else if (stall) begin
                        stall_cnt_q <= stall_cnt_q + TW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign grant       = grant_q;
    assign busy        = (state_q == StLock);
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_oh_fifo_wr_arbiter.sv
// Directed bench for oh_fifo_wr_arbiter: N=4, DW=8, TIMEOUT=4.
module tb_oh_fifo_wr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned IW = 2;
    localparam int unsigned TO = 4;

    logic            wr_clk = 1'b0;
    logic            wr_nreset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            fifo_full;
    logic            fifo_prog_full;
    logic            fifo_wr_en;
    logic [DW+IW:0]  fifo_din;
    logic [N-1:0]    grant;
    logic            busy;
    logic            err_timeout;
    logic            err_clr;

    int n_checks = 0;
    int n_pass   = 0;

    oh_fifo_wr_arbiter #(
        .N      (N),
        .DW     (DW),
        .IW     (IW),
        .TIMEOUT(TO)
    ) dut (
        .wr_clk        (wr_clk),
        .wr_nreset     (wr_nreset),
        .req_valid     (req_valid),
        .req_last      (req_last),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .fifo_full     (fifo_full),
        .fifo_prog_full(fifo_prog_full),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_din      (fifo_din),
        .grant         (grant),
        .busy          (busy),
        .err_timeout   (err_timeout),
        .err_clr       (err_clr)
    );

    always #5 wr_clk = ~wr_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic l, input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_last[i]          = l;
        req_data[i*DW +: DW] = d;
        #1;
    endtask

    function automatic logic [31:0] din(input int id, input logic l, input logic [7:0] d);
        logic [1:0] id2;
        id2 = id[1:0];
        return {21'd0, id2, l, d};
    endfunction

    initial begin
        wr_nreset      = 1'b0;
        req_valid      = '0;
        req_last       = '0;
        req_data       = '0;
        fifo_full      = 1'b0;
        fifo_prog_full = 1'b0;
        err_clr        = 1'b0;
        set_req(0, 1'b0, 1'b1, 8'hA0);

        // Reset state; last is masked while idle
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 0);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_err", err_timeout, 0);
        check("rst_din", fifo_din, din(0, 1'b0, 8'hA0));
        @(negedge wr_clk);
        wr_nreset = 1'b1;
        set_req(0, 1'b0, 1'b0, 8'h00);

        // Single requester, 3-word packet
        tick();
        set_req(2, 1'b1, 1'b0, 8'h21);
        check("s_idle_ready", req_ready, 0);
        check("s_idle_wr", fifo_wr_en, 0);
        tick();
        check("s_grant", grant, 4'b0100);
        check("s_busy", busy, 1);
        check("s_w1_en", fifo_wr_en, 1);
        check("s_w1_din", fifo_din, din(2, 1'b0, 8'h21));
        tick();
        set_req(2, 1'b1, 1'b0, 8'h22);
        check("s_w2_en", fifo_wr_en, 1);
        check("s_w2_din", fifo_din, din(2, 1'b0, 8'h22));
        tick();
        set_req(2, 1'b1, 1'b1, 8'h23);
        check("s_w3_en", fifo_wr_en, 1);
        check("s_w3_din", fifo_din, din(2, 1'b1, 8'h23));
        tick();
        set_req(2, 1'b0, 1'b0, 8'h00);
        check("s_rel_grant", grant, 0);
        check("s_rel_busy", busy, 0);

        // Round robin from reset, all requesters streaming 1-word packets
        wr_nreset = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b1, 8'h10 + 8'(i));
        @(negedge wr_clk);
        wr_nreset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rr_grant", grant, 32'(1) << (k % 4));
            check("rr_wr_en", fifo_wr_en, 1);
            check("rr_din", fifo_din, din(k % 4, 1'b1, 8'h10 + 8'(k % 4)));
            tick();
            check("rr_gap_grant", grant, 0);
            check("rr_gap_wr", fifo_wr_en, 0);
        end
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 1'b0, 8'h00);

        // Full backpressure mid-packet on requester 1
        set_req(1, 1'b1, 1'b0, 8'h31);
        tick();
        check("bp_grant", grant, 4'b0010);
        tick();
        set_req(1, 1'b1, 1'b0, 8'h32);
        fifo_full = 1'b1;
        #1;
        check("bp_ready", req_ready, 0);
        check("bp_wr", fifo_wr_en, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("bp_ready", req_ready, 0);
            check("bp_wr", fifo_wr_en, 0);
            check("bp_hold_grant", grant, 4'b0010);
        end
        check("bp_no_err", err_timeout, 0);
        tick();
        fifo_full = 1'b0;
        #1;
        check("bp_resume_ready", req_ready, 4'b0010);
        check("bp_resume_wr", fifo_wr_en, 1);
        check("bp_resume_din", fifo_din, din(1, 1'b0, 8'h32));
        tick();
        set_req(1, 1'b1, 1'b1, 8'h33);
        check("bp_last_din", fifo_din, din(1, 1'b1, 8'h33));
        tick();
        set_req(1, 1'b0, 1'b0, 8'h00);
        check("bp_rel", grant, 0);

        // prog_full blocks new grants but not a packet in progress
        fifo_prog_full = 1'b1;
        set_req(0, 1'b1, 1'b0, 8'h40);
        tick();
        check("pf_block", grant, 0);
        tick();
        check("pf_block2", grant, 0);
        fifo_prog_full = 1'b0;
        tick();
        check("pf_grant", grant, 4'b0001);
        fifo_prog_full = 1'b1;
        tick();
        set_req(0, 1'b1, 1'b1, 8'h41);
        set_req(2, 1'b1, 1'b1, 8'h42);
        check("pf_cont_wr", fifo_wr_en, 1);
        check("pf_cont_din", fifo_din, din(0, 1'b1, 8'h41));
        check("pf_cont_ready", req_ready, 4'b0001);
        tick();
        set_req(0, 1'b0, 1'b0, 8'h00);
        check("pf_rel", grant, 0);
        tick();
        check("pf_wait", grant, 0);
        fifo_prog_full = 1'b0;
        tick();
        check("pf_next_grant", grant, 4'b0100);
        tick();
        set_req(2, 1'b0, 1'b0, 8'h00);
        check("pf_next_rel", grant, 0);

        // Timeout: requester 3 sends one word then goes silent
        set_req(3, 1'b1, 1'b0, 8'h53);
        tick();
        check("to_grant", grant, 4'b1000);
        tick();
        set_req(3, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < int'(TO) - 1; k++) begin
            tick();
            check("to_hold", grant, 4'b1000);
            check("to_no_err", err_timeout, 0);
            check("to_no_wr", fifo_wr_en, 0);
        end
        tick();
        check("to_release", grant, 0);
        check("to_busy", busy, 0);
        check("to_err", err_timeout, 1);
        err_clr = 1'b1;
        set_req(0, 1'b1, 1'b1, 8'h60);
        set_req(3, 1'b1, 1'b0, 8'h63);
        tick();
        err_clr = 1'b0;
        check("to_err_clr", err_timeout, 0);
        check("to_next_grant", grant, 4'b0001);
        check("to_next_din", fifo_din, din(0, 1'b1, 8'h60));

        // Reset mid-packet, then arbitration restarts at requester 0
        tick();
        set_req(0, 1'b0, 1'b0, 8'h00);
        tick();
        check("mr_grant3", grant, 4'b1000);
        check("mr_wr", fifo_wr_en, 1);
        #2;
        wr_nreset = 1'b0;
        #1;
        check("mr_rst_grant", grant, 0);
        check("mr_rst_ready", req_ready, 0);
        check("mr_rst_wr", fifo_wr_en, 0);
        check("mr_rst_busy", busy, 0);
        set_req(0, 1'b1, 1'b1, 8'h70);
        @(negedge wr_clk);
        wr_nreset = 1'b1;
        tick();
        check("mr_restart", grant, 4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
